// File: rtl/fix_dec_pkg.sv
// Shared definitions for the fixed-point decimator: sample typedef for the
// default format, width helpers and power-of-two checking.
package fix_dec_pkg;

  localparam int N_INT_DEF  = 8;
  localparam int N_MANT_DEF = 23;

  // Signed fixed-point sample in the default n_int/n_mant format
  typedef logic signed [N_INT_DEF+N_MANT_DEF:0] sample_t;

  // Total sample width including the sign bit
  function automatic int sample_width(input int n_int, input int n_mant);
    return n_int + n_mant + 1;
  endfunction

  // Accumulator width: osr full-scale samples can never overflow it
  function automatic int acc_width(input int n_int, input int n_mant, input int osr);
    return sample_width(n_int, n_mant) + $clog2(osr);
  endfunction

  // FIFO read/write pointer width
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // FIFO occupancy width, able to represent 0..depth
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fix_dec_fifo.sv
// First-word-fall-through FIFO for decimated samples. Pointers wrap modulo
// depth (power of two); a push while full with no pop is discarded.
module fix_dec_fifo
  import fix_dec_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [width-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = ptr_width(depth);
  localparam int CW = cnt_width(depth);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(depth);

  logic [width-1:0] mem_q [depth];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push_s, do_pop_s;

  assign empty_o   = (cnt_q == {CW{1'b0}});
  assign full_o    = (cnt_q == CNT_FULL);
  assign do_pop_s  = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the same edge frees a slot
  assign do_push_s = push_i & (~full_o | do_pop_s);
  // Head entry is forced to zero while empty so reset shows a clean output
  assign pop_data_o = empty_o ? {width{1'b0}} : mem_q[rd_q];

  // Next occupancy from the accepted push/pop combination
  always_comb begin
    cnt_d = cnt_q;
    if (do_push_s && !do_pop_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (do_pop_s && !do_push_s) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= {PW{1'b0}};
      rd_q  <= {PW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
      if (do_push_s) wr_q <= wr_q + PTR_ONE;
      if (do_pop_s)  rd_q <= rd_q + PTR_ONE;
    end
  end

  // Storage array; contents are only visible through the occupancy gate
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/fix_decimator.sv
// Fixed-point decimator: averages every osr valid samples (floor) and queues
// the result in an FWFT output FIFO.
// Optional macro FIX_DECIMATOR_OVF_EN adds the sticky FIFO-overflow port ovf.
module fix_decimator
  import fix_dec_pkg::*;
#(
  parameter int n_int      = 8,
  parameter int n_mant     = 23,
  parameter int osr        = 4,
  parameter int fifo_depth = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic signed [n_int+n_mant:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [n_int+n_mant:0] out_data
`ifdef FIX_DECIMATOR_OVF_EN
  ,
  output logic                      ovf
`endif
);

  localparam int SW = sample_width(n_int, n_mant);
  localparam int AW = acc_width(n_int, n_mant, osr);
  localparam int LW = $clog2(osr);
  localparam logic [LW-1:0] PH_LAST = LW'(osr - 1);
  localparam logic [LW-1:0] PH_ONE  = LW'(1);

  if (!is_pow2(osr) || osr < 2 || osr > 256) begin : g_bad_osr
    $error("fix_decimator: osr must be a power of two in 2..256");
  end
  if (!is_pow2(fifo_depth) || fifo_depth < 2 || fifo_depth > 64) begin : g_bad_depth
    $error("fix_decimator: fifo_depth must be a power of two in 2..64");
  end

  logic signed [AW-1:0] acc_q, acc_d, sum_s;
  logic [LW-1:0]        ph_q, ph_d;
  logic                 frame_done_s;
  logic [SW-1:0]        result_s, head_s;
  logic                 full_s, empty_s;

  assign sum_s        = acc_q + {{LW{in_data[SW-1]}}, in_data};
  assign frame_done_s = in_valid & (ph_q == PH_LAST);
  // Dropping the low log2(osr) bits of a two's-complement sum is floor division
  assign result_s     = sum_s[AW-1:LW];

  // Accumulate valid samples; the frame-closing sample reloads to zero
  always_comb begin
    acc_d = acc_q;
    ph_d  = ph_q;
    if (frame_done_s) begin
      acc_d = {AW{1'b0}};
      ph_d  = {LW{1'b0}};
    end else if (in_valid) begin
      acc_d = sum_s;
      ph_d  = ph_q + PH_ONE;
    end else begin
      acc_d = acc_q;
      ph_d  = ph_q;
    end
  end

  // Accumulator and phase counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= {AW{1'b0}};
      ph_q  <= {LW{1'b0}};
    end else begin
      acc_q <= acc_d;
      ph_q  <= ph_d;
    end
  end

  fix_dec_fifo #(
    .width (SW),
    .depth (fifo_depth)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (frame_done_s),
    .push_data_i (result_s),
    .pop_i       (out_ready),
    .pop_data_o  (head_s),
    .full_o      (full_s),
    .empty_o     (empty_s)
  );

  assign out_valid = ~empty_s;
  assign out_data  = head_s;

`ifdef FIX_DECIMATOR_OVF_EN
  logic ovf_q;

  // Sticky flag: a finished frame found the FIFO full with no pop to make room
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (frame_done_s && full_s && !out_ready) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_full_s;
  assign unused_full_s = full_s;
`endif

endmodule

// File: tb/tb_fix_decimator.sv
// Self-checking bench for fix_decimator (osr=4, fifo_depth=4, 32-bit samples).
module tb_fix_decimator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [31:0] in_data = 32'sd0;
  logic               out_ready = 1'b0;
  logic               out_valid;
  logic signed [31:0] out_data;
`ifdef FIX_DECIMATOR_OVF_EN
  logic               ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: samples of the open frame, queued results, sticky flag
  int samples_q[$];
  int fifo_q[$];
  bit ovf_m = 1'b0;

  fix_decimator #(
    .n_int(8), .n_mant(23), .osr(4), .fifo_depth(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FIX_DECIMATOR_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    samples_q.delete();
    fifo_q.delete();
    ovf_m = 1'b0;
  endtask

  // One clock edge of the reference: average of 4 samples, bounded queue of 4
  task automatic model_step();
    bit pop;
    bit push;
    longint s;
    longint q;
    pop  = (fifo_q.size() > 0) && out_ready;
    push = 1'b0;
    q    = 0;
    if (in_valid) begin
      samples_q.push_back(int'(in_data));
      if (samples_q.size() == 4) begin
        s = 0;
        foreach (samples_q[i]) s += longint'(samples_q[i]);
        q = s / 4;
        if ((s % 4 != 0) && (s < 0)) q = q - 1;
        push = 1'b1;
        samples_q.delete();
      end
    end
    if (push && fifo_q.size() == 4 && !pop) begin
      push  = 1'b0;
      ovf_m = 1'b1;
    end
    if (pop)  void'(fifo_q.pop_front());
    if (push) fifo_q.push_back(int'(q));
  endtask

  // Cycle-by-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    n_cmp++;
    if (out_valid !== (fifo_q.size() != 0)) begin
      n_bad++;
      $display("FAIL out_valid: got %b, expected %0d", out_valid, fifo_q.size() != 0);
    end else if (out_valid && (out_data !== fifo_q[0])) begin
      n_bad++;
      $display("FAIL out_data: got %0d, expected %0d", out_data, fifo_q[0]);
    end
`ifdef FIX_DECIMATOR_OVF_EN
    if (ovf !== ovf_m) begin
      n_bad++;
      $display("FAIL ovf: got %b, expected %b", ovf, ovf_m);
    end
`endif
  end

  task automatic step(input logic v, input int d, input logic rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic frame(input int v, input logic rdy);
    for (int i = 0; i < 4; i++) step(1'b1, v, rdy);
  endtask

  task automatic do_reset();
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
`ifdef FIX_DECIMATOR_OVF_EN
    chk("rst_ovf", longint'(ovf), 0);
`endif
    #1;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // 4,8,12,16 -> 10 visible for exactly one cycle after the 16 is sampled
    step(1'b1, 4, 1'b1);
    step(1'b1, 8, 1'b1);
    step(1'b1, 12, 1'b1);
    chk("avg_not_early", longint'(out_valid), 0);
    step(1'b1, 16, 1'b1);
    chk("avg_valid", longint'(out_valid), 1);
    chk("avg_data", longint'(out_data), 10);
    step(1'b0, 0, 1'b1);
    chk("avg_one_cycle", longint'(out_valid), 0);

    // Negative floor and full-scale positive
    step(1'b1, -3, 1'b1);
    step(1'b1, -3, 1'b1);
    step(1'b1, -3, 1'b1);
    step(1'b1, -2, 1'b1);
    chk("neg_floor", longint'(out_data), -3);
    frame(32'sh7fffffff, 1'b1);
    chk("max_pos", longint'(out_data), 2147483647);
    step(1'b0, 0, 1'b1);

    // Same samples with gaps
    step(1'b1, 4, 1'b1);
    step(1'b0, 99, 1'b1);
    step(1'b0, 77, 1'b1);
    step(1'b1, 8, 1'b1);
    step(1'b0, 55, 1'b1);
    step(1'b1, 12, 1'b1);
    step(1'b1, 16, 1'b1);
    chk("gap_avg", longint'(out_data), 10);
    step(1'b0, 0, 1'b1);

    // Overflow: five frames with the consumer stalled
    for (int k = 1; k <= 5; k++) frame(k, 1'b0);
    chk("ovf_head", longint'(out_data), 1);
    step(1'b0, 0, 1'b0);
    chk("ovf_head_stable", longint'(out_data), 1);
`ifdef FIX_DECIMATOR_OVF_EN
    chk("ovf_set", longint'(ovf), 1);
`endif
    for (int k = 1; k <= 4; k++) begin
      chk("drain_order", longint'(out_data), k);
      step(1'b0, 0, 1'b1);
    end
    chk("drain_empty", longint'(out_valid), 0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    frame(10, 1'b0);
    frame(20, 1'b0);
    frame(30, 1'b0);
    frame(40, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 50, 1'b0);
    step(1'b1, 50, 1'b1);
`ifdef FIX_DECIMATOR_OVF_EN
    chk("pushpop_no_ovf", longint'(ovf), 0);
`endif
    for (int k = 2; k <= 5; k++) begin
      chk("pushpop_order", longint'(out_data), 10 * k);
      step(1'b0, 0, 1'b1);
    end
    chk("pushpop_empty", longint'(out_valid), 0);

    // Reset mid-frame discards the partial sum
    step(1'b1, 100, 1'b1);
    step(1'b1, 100, 1'b1);
    do_reset();
    frame(8, 1'b1);
    chk("post_rst_avg", longint'(out_data), 8);
    step(1'b0, 0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
             ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 40)) - 20,
             ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0);
      end
    end
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
